// File: rtl/mc_cpu.sv
// mc_cpu: multi-cycle MIPS-subset core sharing one request/ready memory bus for fetch and data.
// Optional macro ILLEGAL_TRAP_EN: undefined instructions trap to HALT and set the sticky illegal flag.
module mc_cpu #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          NREGS_LOG2 = 5,
    parameter int          CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    output logic             mem_req,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata,
    input  logic             mem_ready,
    output logic [31:0]      PC,
    output logic [2:0]       state,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);
    localparam int NREGS = 1 << NREGS_LOG2;

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_SLL = 6'b000000;

    logic [2:0]       state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      ir_q, ir_d;
    logic [31:0]      a_q, a_d;
    logic [31:0]      b_q, b_d;
    logic [31:0]      alu_q, alu_d;
    logic [31:0]      mdr_q, mdr_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic [31:0]      rf_q [NREGS];

    logic [5:0]            op, funct;
    logic [4:0]            shamt;
    logic [NREGS_LOG2-1:0] rs, rt, rd, wb_dst;
    logic [31:0]           sext_imm, zext_imm, br_off, alu_res, wb_data;
    logic                  rtype_ok, op_ok, undef_instr, wb_we;

    assign op       = ir_q[31:26];
    assign funct    = ir_q[5:0];
    assign shamt    = ir_q[10:6];
    assign rs       = ir_q[21 +: NREGS_LOG2];
    assign rt       = ir_q[16 +: NREGS_LOG2];
    assign rd       = ir_q[11 +: NREGS_LOG2];
    assign sext_imm = {{16{ir_q[15]}}, ir_q[15:0]};
    assign zext_imm = {16'h0000, ir_q[15:0]};
    assign br_off   = {{14{ir_q[15]}}, ir_q[15:0], 2'b00};
    assign wb_dst   = (op == OP_RTYPE) ? rd : rt;
    assign wb_data  = (op == OP_LW) ? mdr_q : alu_q;

    always_comb begin
        rtype_ok = 1'b0;
        case (funct)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_SLL: rtype_ok = 1'b1;
            default: rtype_ok = 1'b0;
        endcase
        op_ok = 1'b0;
        case (op)
            OP_RTYPE, OP_ADDI, OP_ORI, OP_LW, OP_SW,
            OP_BEQ, OP_BNE, OP_J, OP_HALT: op_ok = 1'b1;
            default: op_ok = 1'b0;
        endcase
        undef_instr = !op_ok || ((op == OP_RTYPE) && !rtype_ok);
    end

    always_comb begin
        alu_res = 32'h0;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  alu_res = a_q + b_q;
                    FN_SUB:  alu_res = a_q - b_q;
                    FN_AND:  alu_res = a_q & b_q;
                    FN_OR:   alu_res = a_q | b_q;
                    FN_SLT:  alu_res = {31'h0, $signed(a_q) < $signed(b_q)};
                    FN_SLL:  alu_res = b_q << shamt;
                    default: alu_res = 32'h0;
                endcase
            end
            OP_ADDI, OP_LW, OP_SW: alu_res = a_q + sext_imm;
            OP_ORI:                alu_res = a_q | zext_imm;
            default:               alu_res = 32'h0;
        endcase
    end

`ifdef ILLEGAL_TRAP_EN
    logic illegal_q, illegal_set;
`endif

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        a_d       = a_q;
        b_d       = b_q;
        alu_d     = alu_q;
        mdr_d     = mdr_q;
        retired_d = retired_q;
        wb_we     = 1'b0;
`ifdef ILLEGAL_TRAP_EN
        illegal_set = 1'b0;
`endif
        case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    ir_d    = mem_rdata;
                    pc_d    = pc_q + 32'd4;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d     = rf_q[rs];
                b_d     = rf_q[rt];
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_FETCH;
                if (undef_instr) begin
`ifdef ILLEGAL_TRAP_EN
                    illegal_set = 1'b1;
                    state_d     = S_HALT;
`else
                    retired_d = retired_q + CNT_W'(1);
`endif
                end else begin
                    case (op)
                        OP_RTYPE, OP_ADDI, OP_ORI: begin
                            alu_d   = alu_res;
                            state_d = S_WB;
                        end
                        OP_LW, OP_SW: begin
                            alu_d   = alu_res;
                            state_d = S_MEM;
                        end
                        // pc_q already points past the branch, so the offset is relative to PC+4
                        OP_BEQ, OP_BNE: begin
                            if ((a_q == b_q) == (op == OP_BEQ)) pc_d = pc_q + br_off;
                            retired_d = retired_q + CNT_W'(1);
                        end
                        OP_J: begin
                            pc_d      = {pc_q[31:28], ir_q[25:0], 2'b00};
                            retired_d = retired_q + CNT_W'(1);
                        end
                        default: begin
                            retired_d = retired_q + CNT_W'(1);
                            state_d   = S_HALT;
                        end
                    endcase
                end
            end
            S_MEM: begin
                if (mem_ready) begin
                    if (op == OP_SW) begin
                        retired_d = retired_q + CNT_W'(1);
                        state_d   = S_FETCH;
                    end else begin
                        mdr_d   = mem_rdata;
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                wb_we     = (wb_dst != '0);
                retired_d = retired_q + CNT_W'(1);
                state_d   = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= 32'h0;
            a_q       <= 32'h0;
            b_q       <= 32'h0;
            alu_q     <= 32'h0;
            mdr_q     <= 32'h0;
            retired_q <= '0;
            for (int i = 0; i < NREGS; i++) rf_q[i] <= 32'h0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            a_q       <= a_d;
            b_q       <= b_d;
            alu_q     <= alu_d;
            mdr_q     <= mdr_d;
            retired_q <= retired_d;
            if (wb_we) rf_q[wb_dst] <= wb_data;
        end
    end

`ifdef ILLEGAL_TRAP_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) illegal_q <= 1'b0;
        else if (illegal_set) illegal_q <= 1'b1;
    end
    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

    // Bus outputs are gated by reset so an in-flight request drops the moment reset rises
    assign mem_req   = !reset && ((state_q == S_FETCH) || (state_q == S_MEM));
    assign mem_we    = !reset && (state_q == S_MEM) && (op == OP_SW);
    assign mem_addr  = reset                ? 32'h0 :
                       (state_q == S_FETCH) ? {pc_q[31:2], 2'b00} :
                       (state_q == S_MEM)   ? {alu_q[31:2], 2'b00} : 32'h0;
    assign mem_wdata = mem_we ? b_q : 32'h0;

    assign PC      = pc_q;
    assign state   = state_q;
    assign halted  = (state_q == S_HALT);
    assign retired = retired_q;
endmodule

// File: tb/tb_mc_cpu.sv
// Bench for mc_cpu: a program is run against a memory responder whose bus transactions are
// checked against an expected queue; a second instance covers the jump from a high PC region.
module tb_mc_cpu;
  logic        clk;
  logic        reset;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;
  logic [2:0]  state;
  logic        halted, illegal;
  logic [31:0] retired;

  logic        mem2_req, mem2_we, mem2_ready;
  logic [31:0] mem2_addr, mem2_wdata, mem2_rdata, pc2;
  logic [2:0]  state2;
  logic        halted2, illegal2;
  logic [31:0] retired2;

  localparam logic [31:0] BR_PC = 32'h0000_014C;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          rel_cyc = 0;
  int          fetch_wait;
  int          edge_q[$];
  logic [64:0] exp_q[$];
  logic [31:0] mem [0:1023];

  mc_cpu #(.RESET_PC(32'h0000_0100), .NREGS_LOG2(5), .CNT_W(32)) u_dut (
    .clk(clk), .reset(reset),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .PC(pc), .state(state), .halted(halted), .illegal(illegal), .retired(retired)
  );

  mc_cpu #(.RESET_PC(32'h3000_0000), .NREGS_LOG2(5), .CNT_W(32)) u_dut2 (
    .clk(clk), .reset(reset),
    .mem_req(mem2_req), .mem_we(mem2_we), .mem_addr(mem2_addr), .mem_wdata(mem2_wdata),
    .mem_rdata(mem2_rdata), .mem_ready(mem2_ready),
    .PC(pc2), .state(state2), .halted(halted2), .illegal(illegal2), .retired(retired2)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [64:0] act, input logic [64:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'b000000, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic exp_rd(input logic [31:0] a);
    exp_q.push_back({1'b0, a, 32'h0});
  endtask

  task automatic exp_wr(input logic [31:0] a, input logic [31:0] d);
    exp_q.push_back({1'b1, a, d});
  endtask

  // driver: program image plus the bus transactions it must produce
  task automatic load_program();
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[32'h100 >> 2] = enc_i(6'b001000, 5'd0, 5'd1, 16'd5);
    mem[32'h104 >> 2] = enc_i(6'b001000, 5'd0, 5'd2, 16'hFFFD);
    mem[32'h108 >> 2] = enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'b100000);
    mem[32'h10C >> 2] = enc_i(6'b101011, 5'd0, 5'd3, 16'h0040);
    mem[32'h110 >> 2] = enc_i(6'b100011, 5'd0, 5'd4, 16'h0040);
    mem[32'h114 >> 2] = enc_i(6'b101011, 5'd0, 5'd4, 16'h0044);
    mem[32'h118 >> 2] = enc_i(6'b001000, 5'd0, 5'd0, 16'd7);
    mem[32'h11C >> 2] = enc_i(6'b101011, 5'd0, 5'd0, 16'h0048);
    mem[32'h120 >> 2] = enc_i(6'b001101, 5'd0, 5'd5, 16'hFFFF);
    mem[32'h124 >> 2] = enc_r(5'd0, 5'd5, 5'd6, 5'd4, 6'b000000);
    mem[32'h128 >> 2] = enc_r(5'd2, 5'd1, 5'd7, 5'd0, 6'b100010);
    mem[32'h12C >> 2] = enc_r(5'd7, 5'd1, 5'd8, 5'd0, 6'b101010);
    mem[32'h130 >> 2] = enc_r(5'd5, 5'd7, 5'd9, 5'd0, 6'b100100);
    mem[32'h134 >> 2] = enc_r(5'd1, 5'd6, 5'd10, 5'd0, 6'b100101);
    mem[32'h138 >> 2] = enc_i(6'b101011, 5'd0, 5'd6, 16'h004C);
    mem[32'h13C >> 2] = enc_i(6'b101011, 5'd0, 5'd7, 16'h0050);
    mem[32'h140 >> 2] = enc_i(6'b101011, 5'd0, 5'd8, 16'h0054);
    mem[32'h144 >> 2] = enc_i(6'b101011, 5'd0, 5'd9, 16'h0058);
    mem[32'h148 >> 2] = enc_i(6'b101011, 5'd0, 5'd10, 16'h005C);
    mem[32'h14C >> 2] = enc_i(6'b000100, 5'd1, 5'd1, 16'hFFFF);
    mem[32'h150 >> 2] = enc_i(6'b000100, 5'd1, 5'd2, 16'd5);
    mem[32'h154 >> 2] = enc_i(6'b000101, 5'd1, 5'd2, 16'd1);
    mem[32'h158 >> 2] = enc_i(6'b101011, 5'd0, 5'd1, 16'h0060);
    mem[32'h15C >> 2] = {6'b000010, 26'h000005A};
    mem[32'h160 >> 2] = enc_i(6'b101011, 5'd0, 5'd1, 16'h0064);
    mem[32'h164 >> 2] = enc_i(6'b101011, 5'd0, 5'd1, 16'h0068);
    mem[32'h168 >> 2] = enc_i(6'b001000, 5'd0, 5'd13, 16'h0054);
    mem[32'h16C >> 2] = enc_i(6'b100011, 5'd13, 5'd14, 16'hFFFC);
    mem[32'h170 >> 2] = enc_i(6'b101011, 5'd0, 5'd14, 16'h0060);
    mem[32'h174 >> 2] = 32'h5400_0000;
    mem[32'h178 >> 2] = 32'hFC00_0000;

    exp_rd(32'h100); exp_rd(32'h104); exp_rd(32'h108);
    exp_rd(32'h10C); exp_wr(32'h40, 32'h2);
    exp_rd(32'h110); exp_rd(32'h40);
    exp_rd(32'h114); exp_wr(32'h44, 32'h2);
    exp_rd(32'h118);
    exp_rd(32'h11C); exp_wr(32'h48, 32'h0);
    exp_rd(32'h120); exp_rd(32'h124); exp_rd(32'h128); exp_rd(32'h12C);
    exp_rd(32'h130); exp_rd(32'h134);
    exp_rd(32'h138); exp_wr(32'h4C, 32'h000F_FFF0);
    exp_rd(32'h13C); exp_wr(32'h50, 32'hFFFF_FFF8);
    exp_rd(32'h140); exp_wr(32'h54, 32'h0000_0001);
    exp_rd(32'h144); exp_wr(32'h58, 32'h0000_FFF8);
    exp_rd(32'h148); exp_wr(32'h5C, 32'h000F_FFF5);
    exp_rd(32'h14C); exp_rd(32'h14C); exp_rd(32'h150); exp_rd(32'h154);
    exp_rd(32'h15C); exp_rd(32'h168);
    exp_rd(32'h16C); exp_rd(32'h50);
    exp_rd(32'h170); exp_wr(32'h60, 32'hFFFF_FFF8);
    exp_rd(32'h174);
`ifndef ILLEGAL_TRAP_EN
    exp_rd(32'h178);
`endif
  endtask

  // scoreboard-side memory responder for the main instance
  initial begin
    logic        busy, is_data;
    logic        lat_we;
    logic [31:0] lat_addr, lat_wdata;
    logic [64:0] act, exp;
    int          wait_left, dacc, br_hits;
    busy = 1'b0; is_data = 1'b0; lat_we = 1'b0; lat_addr = 32'h0; lat_wdata = 32'h0;
    wait_left = 0; dacc = 0; br_hits = 0;
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      #1;
      if (!mem_req) begin
        mem_ready = 1'b0;
        busy = 1'b0;
      end else begin
        if (!busy) begin
          busy      = 1'b1;
          lat_we    = mem_we;
          lat_addr  = mem_addr;
          lat_wdata = mem_wdata;
          is_data   = (mem_addr < 32'h100);
          wait_left = is_data ? ((dacc == 1) ? 3 : 0) : fetch_wait;
        end else begin
          check("bus_hold", {mem_we, mem_addr, mem_wdata}, {lat_we, lat_addr, lat_wdata});
        end
        if (wait_left > 0) begin
          mem_ready = 1'b0;
          wait_left--;
        end else begin
          mem_ready = 1'b1;
          busy = 1'b0;
          if (is_data) dacc++;
          act = {mem_we, mem_addr, mem_we ? mem_wdata : 32'h0};
          exp = (exp_q.size() > 0) ? exp_q.pop_front() : {1'b1, 64'hFFFF_FFFF_FFFF_FFFF};
          check("bus_txn", act, exp);
          edge_q.push_back(cyc + 1 - rel_cyc);
          if (mem_we) begin
            mem[mem_addr[11:2]] = mem_wdata;
          end else if (mem_addr == BR_PC) begin
            // the second visit to the self-loop sees a bne so the loop exits
            mem_rdata = (br_hits > 0) ? enc_i(6'b000101, 5'd1, 5'd1, 16'hFFFF) : mem[mem_addr[11:2]];
            br_hits++;
          end else begin
            mem_rdata = mem[mem_addr[11:2]];
          end
        end
      end
    end
  end

  // zero-wait responder for the high-region instance: j 0x10 at 0x3000_0000, halt elsewhere
  initial begin
    mem2_ready = 1'b1;
    mem2_rdata = 32'h0;
    forever begin
      @(negedge clk);
      #1;
      mem2_rdata = (mem2_addr == 32'h3000_0000) ? 32'h0800_0010 : 32'hFC00_0000;
    end
  end

  initial begin
    int hi;
    reset = 1'b1;
    fetch_wait = 5;
    load_program();
    repeat (3) @(negedge clk);
    #2;
    check("rst_req", 65'(mem_req), 65'd0);
    check("rst_we", 65'(mem_we), 65'd0);
    check("rst_addr", 65'(mem_addr), 65'd0);
    check("rst_wdata", 65'(mem_wdata), 65'd0);
    check("rst_state", 65'(state), 65'd0);
    check("rst_pc", 65'(pc), 65'h100);
    check("rst_retired", 65'(retired), 65'd0);
    check("rst_halted", 65'(halted), 65'd0);
    check("rst_illegal", 65'(illegal), 65'd0);

    @(negedge clk);
    reset = 1'b0;
    #2;
    check("fetch_req", 65'(mem_req), 65'd1);
    check("fetch_addr", 65'(mem_addr), 65'h100);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("req_async_drop", 65'(mem_req), 65'd0);
    check("abort_pc", 65'(pc), 65'h100);
    fetch_wait = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    rel_cyc = cyc;
    #2;
    check("j_first_fetch", 65'(mem2_addr), 65'h3000_0000);

    repeat (3) @(posedge clk);
    @(negedge clk);
    #2;
    check("j_target", 65'(mem2_addr), 65'h3000_0040);
    check("j_req", 65'(mem2_req), 65'd1);

    repeat (13) @(posedge clk);
    @(negedge clk);
    #2;
    check("retired_16cyc", 65'(retired), 65'd4);

    for (int i = 0; i < 1000 && !halted; i++) @(negedge clk);
    #2;
    check("halt_reached", 65'(halted), 65'd1);
    check("halt_state", 65'(state), 65'd5);
    check("sb_empty", 65'(exp_q.size()), 65'd0);
`ifdef ILLEGAL_TRAP_EN
    check("final_retired", 65'(retired), 65'd27);
    check("final_illegal", 65'(illegal), 65'd1);
    check("final_pc", 65'(pc), 65'h178);
`else
    check("final_retired", 65'(retired), 65'd29);
    check("final_illegal", 65'(illegal), 65'd0);
    check("final_pc", 65'(pc), 65'h17C);
`endif

    hi = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #2;
      if (mem_req) hi++;
    end
    check("halt_req_low", 65'(hi), 65'd0);
    check("halt_stays", 65'(halted), 65'd1);

    check("txn_count_ok", 65'(edge_q.size() >= 34), 65'd1);
    if (edge_q.size() >= 34) begin
      check("sw_write_edge", 65'(edge_q[4]), 65'd16);
      check("sw_cpi", 65'(edge_q[5] - edge_q[3]), 65'd4);
      check("lw_wait_cpi", 65'(edge_q[7] - edge_q[5]), 65'd8);
      check("beq_cpi", 65'(edge_q[29] - edge_q[28]), 65'd3);
      check("j_cpi", 65'(edge_q[33] - edge_q[32]), 65'd3);
    end

    check("dut2_halted", 65'(halted2), 65'd1);
    check("dut2_retired", 65'(retired2), 65'd2);
    check("dut2_pc", 65'(pc2), 65'h3000_0044);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
